score_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter for score and HUD display paths.
- Uses shift-and-add-3 (double dabble), one bit per clock, with a start/done handshake.
- Adds saturation on overflow and a leading-zero blanking mask for the 7-segment and VGA digit renderers.
- Replaces wide comparator chains with small iterative logic that scales with BIN_W and DIGITS.

---
 rtl/score_bcd_seq_pkg.sv | 25 ++
 rtl/score_bcd_seq_bcd_digit_adj.sv | 13 +
 rtl/score_bcd_seq.sv | 124 ++++++++++++
 tb/tb_score_bcd_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/score_bcd_seq_pkg.sv
// Shared constants, FSM states and reset helpers for the sequential binary-to-BCD converter.
package score_bcd_seq_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;
    localparam logic [BCD_W-1:0] BCD_NINE    = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Blank every digit except the units digit, so a cleared display shows a single "0".
    function automatic logic [63:0] lz_rst_mask(input int unsigned digits);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 1; i < digits && i < 64; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/score_bcd_seq_bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more before the next shift.
module bcd_digit_adj
    import score_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] dig_i,
    output logic [BCD_W-1:0] dig_o
);

    always_comb begin
        dig_o = (dig_i >= ADD3_THRESH) ? dig_i + ADD3_VAL : dig_i;
    end

endmodule

// File: rtl/score_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with
// start/done handshake, saturation on overflow and a leading-zero blanking mask.
module score_bcd_seq
    import score_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 17,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow,
    output logic [DIGITS-1:0]         lz_mask
);

    localparam int unsigned CNT_W   = $clog2(BIN_W);
    localparam int unsigned BCD_TOT = BCD_W * DIGITS;
    localparam logic [DIGITS-1:0] LZ_RST = DIGITS'(lz_rst_mask(DIGITS));

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIN_W-1:0]     shreg_q;
    logic [BCD_TOT-1:0]   dig_q;
    logic                 sticky_q;
    logic                 busy_q;
    logic                 done_q;
    logic [BCD_TOT-1:0]   bcd_q;
    logic                 ovf_q;
    logic [DIGITS-1:0]    lz_q;

    logic [BCD_TOT-1:0]   dig_adj;
    logic [BCD_TOT-1:0]   sh_dig_d;
    logic [BIN_W-1:0]     sh_reg_d;
    logic                 sticky_d;
    logic [BCD_TOT-1:0]   pub_bcd_d;
    logic [DIGITS-1:0]    lz_d;
    logic                 zrun;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (dig_q[g*BCD_W +: BCD_W]),
            .dig_o (dig_adj[g*BCD_W +: BCD_W])
        );
    end

    // One shift step of {digits, shreg}; the bit falling off the top digit is the overflow.
    always_comb begin
        sh_dig_d  = {dig_adj[BCD_TOT-2:0], shreg_q[BIN_W-1]};
        sh_reg_d  = {shreg_q[BIN_W-2:0], 1'b0};
        sticky_d  = sticky_q | dig_adj[BCD_TOT-1];
        pub_bcd_d = sticky_d ? {DIGITS{BCD_NINE}} : sh_dig_d;
    end

    // Walk down from the top digit; a digit is blankable while everything above it is zero.
    always_comb begin
        zrun = 1'b1;
        lz_d = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            zrun = zrun & (pub_bcd_d[BCD_W*(DIGITS-i) +: BCD_W] == '0);
            lz_d[DIGITS-i] = zrun;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dig_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            lz_q     <= LZ_RST;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        shreg_q  <= bin;
                        dig_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CNT_W'(BIN_W - 1);
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shreg_q  <= sh_reg_d;
                    dig_q    <= sh_dig_d;
                    sticky_q <= sticky_d;
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= pub_bcd_d;
                        ovf_q   <= sticky_d;
                        lz_q    <= lz_d;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign lz_mask  = lz_q;

endmodule

// File: tb/tb_score_bcd_seq.sv
// Randomised self-checking bench for score_bcd_seq: default build and an 8-bit/2-digit build.
module tb_score_bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0;
    logic [16:0] bin_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;
    logic [4:0]  lz_a;

    logic        start_b = 1'b0;
    logic [7:0]  bin_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  lz_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_bcd_seq #(.BIN_W(17), .DIGITS(5)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .lz_mask(lz_a)
    );

    score_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .lz_mask(lz_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, saturate when the value needs more digits than exist.
    function automatic void model(input longint unsigned v, input int unsigned nd,
                                  output logic [63:0] e_bcd, output logic e_ovf,
                                  output logic [63:0] e_lz);
        longint unsigned p;
        longint unsigned lim;
        lim = 1;
        for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
        e_ovf = (v >= lim);
        e_bcd = '0;
        e_lz  = '0;
        p = 1;
        for (int unsigned i = 0; i < nd; i++) begin
            e_bcd[4*i +: 4] = e_ovf ? 4'h9 : 4'((v / p) % 10);
            if (i >= 1 && !e_ovf && v < p) e_lz[i] = 1'b1;
            p = p * 10;
        end
    endfunction

    task automatic wait_done(input bit sel, output int nbusy, output int nedge, output bit ok);
        nbusy = 0;
        nedge = 0;
        ok    = 1'b0;
        while (!ok && nedge < 100) begin
            if (sel ? done_b : done_a) begin
                ok = 1'b1;
            end else begin
                if (sel ? busy_b : busy_a) nbusy++;
                @(posedge clk); #1;
                nedge++;
            end
        end
    endtask

    task automatic convert(input bit sel, input int unsigned v, input string tag);
        int nb, ne;
        bit ok;
        logic [63:0] eb, el;
        logic eo;
        logic [63:0] held;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; bin_b = 8'(v); end
        else     begin start_a = 1'b1; bin_a = 17'(v); end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        wait_done(sel, nb, ne, ok);
        model(longint'(v), sel ? 2 : 5, eb, eo, el);
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nb), sel ? 64'd8 : 64'd17);
        check({tag, "_bcd"}, sel ? 64'(bcd_b) : 64'(bcd_a), eb);
        check({tag, "_ovf"}, sel ? 64'(ovf_b) : 64'(ovf_a), 64'(eo));
        check({tag, "_lz"}, sel ? 64'(lz_b) : 64'(lz_a), el);
        @(posedge clk); #1;
        held = sel ? 64'(bcd_b) : 64'(bcd_a);
        check({tag, "_done_pulse"}, sel ? 64'(done_b) : 64'(done_a), 64'd0);
        check({tag, "_hold"}, held, eb);
    endtask

    initial begin
        int nb, ne;
        bit ok;
        bit seen;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd", 64'(bcd_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_lz", 64'(lz_a), 64'b11110);
        check("rst_lz_b", 64'(lz_b), 64'b10);

        convert(1'b0, 12345, "a12345");
        convert(1'b0, 0, "a0");
        convert(1'b0, 42, "a42");
        convert(1'b0, 99999, "a99999");
        convert(1'b0, 100000, "a100000");
        convert(1'b0, 131071, "a131071");

        // start held every cycle; bin changes mid-conversion and must not disturb it
        @(negedge clk); start_a = 1'b1; bin_a = 17'd7;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        @(negedge clk); bin_a = 17'd500;
        wait_done(1'b0, nb, ne, ok);
        check("hs_done_seen", 64'(ok), 64'd1);
        check("hs_bcd7", 64'(bcd_a), 64'h00007);
        @(posedge clk); #1;
        start_a = 1'b0;
        check("hs_reaccept_busy", 64'(busy_a), 64'd1);
        wait_done(1'b0, nb, ne, ok);
        check("hs_done2_seen", 64'(ok), 64'd1);
        check("hs_bcd500", 64'(bcd_a), 64'h00500);
        check("hs_b2b_gap", 64'(ne + 1), 64'd18);
        @(posedge clk); #1;

        // reset during the ninth shift cycle of 54321
        seen = 1'b0;
        @(negedge clk); start_a = 1'b1; bin_a = 17'd54321;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_a) seen = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_bcd", 64'(bcd_a), 64'd0);
        check("abort_lz", 64'(lz_a), 64'b11110);
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        convert(1'b0, 54321, "a54321");

        for (int i = 0; i < 30; i++) begin
            convert(1'b0, $urandom_range(131071, 0), "arnd");
        end
        for (int i = 0; i < 6; i++) begin
            convert(1'b0, $urandom_range(100001, 99998), "aedge");
        end

        convert(1'b1, 255, "b255");
        convert(1'b1, 99, "b99");
        convert(1'b1, 5, "b5");
        convert(1'b1, 0, "b0");
        convert(1'b1, 100, "b100");
        for (int i = 0; i < 20; i++) begin
            convert(1'b1, $urandom_range(255, 0), "brnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
